// File: rtl/dest_match_unit_pkg.sv
// Shared definitions for the destination-match lookup: default widths and FSM encoding.
package dest_match_unit_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam logic [WORD_WIDTH_DEF-1:0] BCAST_ID_DEF = {WORD_WIDTH_DEF{1'b1}};

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    IDLE   = 2'd1,
    SCAN   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/dest_match_unit_id_table.sv
// Local node ID table: one write port, one combinational read port, valid bits cleared on reset.
module dest_match_unit_id_table
  import dest_match_unit_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int NUM_IDS    = 4,
  parameter int IDX_W      = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [WORD_WIDTH-1:0] wr_id_i,
  input  logic                  wr_vld_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [WORD_WIDTH-1:0] rd_id_o,
  output logic                  rd_vld_o
);

  logic [WORD_WIDTH-1:0] id_q [NUM_IDS];
  logic [NUM_IDS-1:0]    vld_q;
  logic                  wr_ok;

  // Out-of-range indices are dropped so a non-power-of-two table never aliases.
  assign wr_ok = wr_en_i && (32'(wr_idx_i) < 32'(NUM_IDS));

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      vld_q <= '0;
    end else if (wr_ok) begin
      vld_q[wr_idx_i] <= wr_vld_i;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      id_q[wr_idx_i] <= wr_id_i;
    end
  end

  assign rd_id_o  = id_q[rd_idx_i];
  assign rd_vld_o = vld_q[rd_idx_i];

endmodule

// File: rtl/dest_match_unit.sv
// Iterative destination lookup against a loadable ID table, with mask and broadcast detection.
module dest_match_unit
  import dest_match_unit_pkg::*;
#(
  parameter int                    WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int                    NUM_IDS    = 4,
  parameter int                    IDX_W      = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
  parameter bit                    BCAST_EN   = 1'b1,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = {WORD_WIDTH{1'b1}}
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [WORD_WIDTH-1:0] match_mask,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [WORD_WIDTH-1:0] cfg_id,
  input  logic                  cfg_valid,
  output logic                  iamDestination,
  output logic                  isBroadcast,
  output logic [IDX_W-1:0]      match_idx,
  output logic                  done,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] dest_q, dest_d;
  logic [WORD_WIDTH-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      midx_q, midx_d;
  logic                  iam_q, iam_d;
  logic                  bc_q, bc_d;
  logic                  done_q, done_d;

  logic [WORD_WIDTH-1:0] tbl_id;
  logic                  tbl_vld;
  logic                  hit;
  logic                  last;
  logic                  is_bcast;

  dest_match_unit_id_table #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_IDS    (NUM_IDS),
    .IDX_W      (IDX_W)
  ) u_id_table (
    .clock    (clock),
    .nrst     (nrst),
    .wr_en_i  (cfg_we),
    .wr_idx_i (cfg_idx),
    .wr_id_i  (cfg_id),
    .wr_vld_i (cfg_valid),
    .rd_idx_i (idx_q),
    .rd_id_o  (tbl_id),
    .rd_vld_o (tbl_vld)
  );

  assign hit      = tbl_vld && (((tbl_id ^ dest_q) & ~mask_q) == '0);
  assign last     = (idx_q == IDX_W'(NUM_IDS - 1));
  // Broadcast is recognised on the raw destination; the mask only applies to table entries.
  assign is_bcast = BCAST_EN && (destinationID == BCAST_ID);

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (en) state_d = IDLE;
      IDLE:    if (start) state_d = is_bcast ? FINISH : SCAN;
      SCAN:    if (hit || last) state_d = FINISH;
      FINISH:  state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    dest_d = dest_q;
    mask_d = mask_q;
    idx_d  = idx_q;
    midx_d = midx_q;
    iam_d  = iam_q;
    bc_d   = bc_q;
    done_d = done_q;
    case (state_q)
      HOLD: begin
        if (en) begin
          iam_d  = 1'b0;
          bc_d   = 1'b0;
          midx_d = '0;
          done_d = 1'b0;
        end
      end
      IDLE: begin
        if (start) begin
          dest_d = destinationID;
          mask_d = match_mask;
          idx_d  = '0;
          if (is_bcast) begin
            iam_d = 1'b1;
            bc_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (hit) begin
          iam_d  = 1'b1;
          midx_d = idx_q;
        end else if (last) begin
          iam_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FINISH:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      dest_q <= '0;
      mask_q <= '0;
      idx_q  <= '0;
      midx_q <= '0;
      iam_q  <= 1'b0;
      bc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dest_q <= dest_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      midx_q <= midx_d;
      iam_q  <= iam_d;
      bc_q   <= bc_d;
      done_q <= done_d;
    end
  end

  assign iamDestination = iam_q;
  assign isBroadcast    = bc_q;
  assign match_idx      = midx_q;
  assign done           = done_q;
  assign busy           = (state_q == SCAN) || (state_q == FINISH);

endmodule

// File: doc/dest_match_unit.md
Name: dest_match_unit

Overview:
- Parametrised successor of the single-ID destination check in the packet-routing path.
- Compares an incoming destinationID against a runtime-loadable table of NUM_IDS local node IDs, with a per-packet don't-care mask and an optional broadcast ID.
- Scans iteratively, one entry per cycle, and reports hit, broadcast, and matching index.
- Keeps the team's en/start/done handshake so it drops into the existing per-node control sequencer.

Parameters:
- WORD_WIDTH, 16, width of node IDs and mask.
- NUM_IDS, 4, number of local ID table entries (>=1).
- IDX_W, max(1,clog2(NUM_IDS)), width of table index.
- BCAST_EN, 1, enables broadcast-ID detection.
- BCAST_ID, {WORD_WIDTH{1'b1}}, broadcast address.

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-high reset (1 = reset asserted).
- en  in  1  re-arm: leaves HOLD, clears results.
- start  in  1  begin a lookup; sampled only in IDLE.
- destinationID  in  WORD_WIDTH  packet destination; captured when start is accepted.
- match_mask  in  WORD_WIDTH  1 = bit ignored in table compare; captured with destinationID.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_id  in  WORD_WIDTH  ID value to write.
- cfg_valid  in  1  valid bit to write.
- iamDestination  out  1  lookup hit (table or broadcast).
- isBroadcast  out  1  hit was the broadcast ID.
- match_idx  out  IDX_W  lowest matching table index; 0 on miss or broadcast.
- done  out  1  result valid; held until en.
- busy  out  1  high in SCAN and FINISH.

Behaviour:
- Reset (async, nrst=1): state=HOLD; iamDestination, isBroadcast, match_idx, done, busy = 0; all table valid bits = 0; captured regs = 0.
- All registered outputs change only on clock edges, except on asynchronous reset.
- HOLD: if en, clear iamDestination, isBroadcast, match_idx and done, then go to IDLE. Otherwise stay. This is the post-reset state.
- IDLE: if start, capture destinationID and match_mask, and set scan index to 0.
  - If BCAST_EN and destinationID==BCAST_ID (mask not applied): set iamDestination=1 and isBroadcast=1, go to FINISH.
  - Otherwise go to SCAN.
- SCAN: entry i hits when valid[i] && ((id[i]^dest)&~mask)==0.
  - On hit: set iamDestination=1, match_idx=i, go to FINISH.
  - On miss at i==NUM_IDS-1: set iamDestination=0, go to FINISH.
  - Otherwise increment i.
  - First (lowest-index) hit wins.
- FINISH: set done=1, go to HOLD. Results stay stable in HOLD until en.
- Latency, with start accepted at edge k:
  - Broadcast: done=1 after edge k+1.
  - Hit at entry i: done after edge k+2+i.
  - Full miss: done after edge k+1+NUM_IDS.
- en outside HOLD: ignored. start outside IDLE: ignored (no queuing).
- Table writes:
  - Accepted in every state.
  - Take effect at the edge.
  - A compare in the same cycle reads the pre-write value.
  - cfg_idx >= NUM_IDS: write ignored.
- Inputs destinationID/match_mask changing after capture: no effect on the lookup in flight.
- All-ones match_mask: any valid entry matches, so the result is the lowest valid index. If no entry is valid, the result is a miss.
- Reset mid-operation: immediate return to the reset values. The table is also cleared, so software must reload it.
- Illegal state encoding: recover to HOLD.

Decomposition:
- Shared package: WORD_WIDTH default; state encoding constants HOLD, IDLE, SCAN, FINISH; BCAST_ID default.
- Sub-module id_table:
  - NUM_IDS x (WORD_WIDTH+1) register file with valid bits.
  - One write port (cfg_*), one combinational read port by scan index.
  - Async clear of valid bits on nrst.
- The FSM, capture registers and compare logic live in dest_match_unit.

Test Plan:
1. Reset, en pulse, load entry 2 = 0x0042 (valid), start with dest=0x0042, mask=0 → done rises 4 cycles after start edge; iamDestination=1, match_idx=2, isBroadcast=0.
2. Table {0x0010, 0x0011, 0x0012, 0x0013} valid, dest=0x00FF → done after edge k+5; iamDestination=0, match_idx=0. en then clears done next cycle.
3. dest=0xFFFF with BCAST_EN=1 → done after edge k+1; iamDestination=1, isBroadcast=1; table not scanned (busy high 1 cycle).
4. Entries 1=0x1234 and 3=0x12FF, dest=0x12AB, mask=0x00FF → hit at idx 1 (lowest wins), done at k+3.
5. During SCAN, write entry 0 invalid while it is being compared; also pulse start and en mid-scan → compare uses old value; start and en ignored; single done.
6. Assert nrst while in SCAN → outputs 0 immediately; valid bits cleared; after reset a lookup of a previously loaded ID misses.
